// File: rtl/snake_move_planner.sv
// Plans one move per game tick that walks the snake head toward a latched
// target cell on a wrap-around grid, correcting x fully before y.
module snake_move_planner #(
  parameter logic [3:0] GRID_XMAX = 4'd11,
  parameter logic [3:0] GRID_YMAX = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       step,
  input  logic [3:0] target_x,
  input  logic [3:0] target_y,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  output logic [1:0] nextMove,
  output logic       move_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [4:0] XSPAN = {1'b0, GRID_XMAX} + 5'd1;
  localparam logic [4:0] YSPAN = {1'b0, GRID_YMAX} + 5'd1;

  localparam logic [1:0] MOVE_YINC = 2'b00;
  localparam logic [1:0] MOVE_YDEC = 2'b01;
  localparam logic [1:0] MOVE_XINC = 2'b10;
  localparam logic [1:0] MOVE_XDEC = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] tgtX_q, tgtX_d;
  logic [3:0] tgtY_q, tgtY_d;
  logic [1:0] move_q, move_d;
  logic       moveValid_q, moveValid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] count_q, count_d;

  logic [1:0] rstSync_q;
  logic       rstSyncN;

  // Reset asserts asynchronously but releases only after two clean edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncN = rstSync_q[1];

  // True when the backward (decrementing) path around the ring is strictly shorter.
  function automatic logic goBackward(input logic [3:0] tgt, input logic [3:0] pos,
                                      input logic [4:0] span);
    logic [4:0] fwd;
    logic [4:0] bwd;
    if (tgt >= pos) begin
      fwd = {1'b0, tgt} - {1'b0, pos};
    end else begin
      fwd = {1'b0, tgt} + span - {1'b0, pos};
    end
    bwd = span - fwd;
    return (fwd > bwd);
  endfunction

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      state_q     <= IDLE;
      tgtX_q      <= 4'd0;
      tgtY_q      <= 4'd0;
      move_q      <= 2'b00;
      moveValid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      tgtX_q      <= tgtX_d;
      tgtY_q      <= tgtY_d;
      move_q      <= move_d;
      moveValid_q <= moveValid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgtX_d      = tgtX_q;
    tgtY_d      = tgtY_q;
    move_d      = move_q;
    moveValid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((target_x <= GRID_XMAX) && (target_y <= GRID_YMAX)) begin
            tgtX_d  = target_x;
            tgtY_d  = target_y;
            count_d = 8'd0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          if ((head_x == tgtX_q) && (head_y == tgtY_q)) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            moveValid_d = 1'b1;
            if (head_x != tgtX_q) begin
              move_d = goBackward(tgtX_q, head_x, XSPAN) ? MOVE_XDEC : MOVE_XINC;
            end else begin
              move_d = goBackward(tgtY_q, head_y, YSPAN) ? MOVE_YDEC : MOVE_YINC;
            end
            if (count_q != 8'hFF) begin
              count_d = count_q + 8'd1;
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign nextMove   = move_q;
  assign move_valid = moveValid_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign err        = err_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_snake_move_planner.sv
// Randomized bench for snake_move_planner: a wrap-around grid mover feeds the
// head back, and a plan-level reference model predicts every output each cycle.
module tb_snake_move_planner;

  localparam int XMAX = 11;
  localparam int YMAX = 8;
  localparam int XN   = XMAX + 1;
  localparam int YN   = YMAX + 1;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       step;
  logic [3:0] target_x;
  logic [3:0] target_y;
  logic [3:0] head_x;
  logic [3:0] head_y;
  logic [1:0] nextMove;
  logic       move_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] step_count;

  int vectors;
  int miscompares;

  // Reference model: plan phase (0 waiting, 1 planning, 2 finishing) plus outputs.
  int mPhase;
  int mTx;
  int mTy;
  int mCount;
  int mMove;
  bit mValid;
  bit mDone;
  bit mErr;

  // Grid head position maintained by the bench's own mover.
  int hx;
  int hy;
  bit moverOn;

  snake_move_planner #(
    .GRID_XMAX(4'd11),
    .GRID_YMAX(4'd8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .step      (step),
    .target_x  (target_x),
    .target_y  (target_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .nextMove  (nextMove),
    .move_valid(move_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fwdDist(input int tgt, input int pos, input int n);
    return ((tgt - pos) % n + n) % n;
  endfunction

  task automatic modelReset();
    mPhase = 0;
    mTx    = 0;
    mTy    = 0;
    mCount = 0;
    mMove  = 0;
    mValid = 0;
    mDone  = 0;
    mErr   = 0;
  endtask

  task automatic modelEdge(input bit st, input bit ab, input bit sp, input int tx, input int ty);
    int f;
    mValid = 0;
    mDone  = 0;
    mErr   = 0;
    case (mPhase)
      0: begin
        if (st) begin
          if (tx <= XMAX && ty <= YMAX) begin
            mTx    = tx;
            mTy    = ty;
            mCount = 0;
            mPhase = 1;
          end else begin
            mErr = 1;
          end
        end
      end
      1: begin
        if (ab) begin
          mPhase = 0;
        end else if (sp) begin
          if (hx == mTx && hy == mTy) begin
            mPhase = 2;
            mDone  = 1;
          end else begin
            if (hx != mTx) begin
              f = fwdDist(mTx, hx, XN);
              mMove = (f > XN - f) ? 3 : 2;
            end else begin
              f = fwdDist(mTy, hy, YN);
              mMove = (f > YN - f) ? 1 : 0;
            end
            mValid = 1;
            if (mCount < 255) mCount++;
          end
        end
      end
      default: mPhase = 0;
    endcase
  endtask

  task automatic checkAll(input string pfx);
    checkOutput({pfx, ".busy"}, 8'(busy), 8'(mPhase == 1));
    checkOutput({pfx, ".done"}, 8'(done), 8'(mDone));
    checkOutput({pfx, ".err"}, 8'(err), 8'(mErr));
    checkOutput({pfx, ".move_valid"}, 8'(move_valid), 8'(mValid));
    checkOutput({pfx, ".nextMove"}, 8'(nextMove), 8'(mMove));
    checkOutput({pfx, ".step_count"}, step_count, 8'(mCount));
  endtask

  task automatic moverUpdate();
    if (moverOn && mValid) begin
      case (mMove)
        0: hy = (hy + 1) % YN;
        1: hy = (hy + YN - 1) % YN;
        2: hx = (hx + 1) % XN;
        default: hx = (hx + XN - 1) % XN;
      endcase
    end
  endtask

  task automatic applyStimulus(input string tag, input bit st, input bit ab, input bit sp,
                               input int tx, input int ty);
    start    = st;
    abort    = ab;
    step     = sp;
    target_x = tx[3:0];
    target_y = ty[3:0];
    head_x   = hx[3:0];
    head_y   = hy[3:0];
    @(posedge clk);
    modelEdge(st, ab, sp, tx, ty);
    #1;
    checkAll(tag);
    moverUpdate();
    start = 1'b0;
    abort = 1'b0;
    step  = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll({tag, ".immediate"});
    @(posedge clk);
    #1;
    checkAll({tag, ".held"});
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus({tag, ".release"}, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    step        = 1'b0;
    target_x    = 4'd0;
    target_y    = 4'd0;
    head_x      = 4'd0;
    head_y      = 4'd0;
    vectors     = 0;
    miscompares = 0;
    hx          = 0;
    hy          = 0;
    moverOn     = 1;
    modelReset();

    #1;
    checkAll("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("idle", 0, 0, 0, 0, 0);

    // Basic plan: x corrected first, then y, done after head reaches target.
    applyStimulus("p32.start", 1, 0, 0, 3, 2);
    for (int i = 0; i < 6; i++) applyStimulus("p32.step", 0, 0, 1, 0, 0);
    checkOutput("p32.done_seen", 8'(done), 8'd1);
    checkOutput("p32.count", step_count, 8'd5);
    applyStimulus("p32.back", 0, 0, 0, 0, 0);
    checkOutput("p32.idle", 8'(busy), 8'd0);

    // Wrap move: one x-1 step from column 0 to column 11.
    hx = 0; hy = 0;
    applyStimulus("wrap.start", 1, 0, 0, 11, 0);
    applyStimulus("wrap.step", 0, 0, 1, 0, 0);
    checkOutput("wrap.move", 8'(nextMove), 8'd3);
    applyStimulus("wrap.fin", 0, 0, 1, 0, 0);
    checkOutput("wrap.count", step_count, 8'd1);
    applyStimulus("wrap.back", 0, 0, 0, 0, 0);

    // Tie breaks forward in x; y picks forward at 4 and backward at 5.
    hx = 0; hy = 0;
    applyStimulus("tie.start", 1, 0, 0, 6, 0);
    applyStimulus("tie.step", 0, 0, 1, 0, 0);
    checkOutput("tie.move", 8'(nextMove), 8'd2);
    for (int i = 0; i < 8; i++) applyStimulus("tie.run", 0, 0, 1, 0, 0);
    hx = 0; hy = 0;
    applyStimulus("y4.start", 1, 0, 0, 0, 4);
    applyStimulus("y4.step", 0, 0, 1, 0, 0);
    checkOutput("y4.move", 8'(nextMove), 8'd0);
    for (int i = 0; i < 6; i++) applyStimulus("y4.run", 0, 0, 1, 0, 0);
    hx = 0; hy = 0;
    applyStimulus("y5.start", 1, 0, 0, 0, 5);
    applyStimulus("y5.step", 0, 0, 1, 0, 0);
    checkOutput("y5.move", 8'(nextMove), 8'd1);
    for (int i = 0; i < 6; i++) applyStimulus("y5.run", 0, 0, 1, 0, 0);

    // Out-of-range target is rejected without disturbing the last count.
    applyStimulus("oor.start", 1, 0, 0, 12, 3);
    checkOutput("oor.err", 8'(err), 8'd1);
    checkOutput("oor.busy", 8'(busy), 8'd0);
    checkOutput("oor.count", step_count, 8'd4);
    applyStimulus("oor.after", 0, 0, 0, 0, 0);
    checkOutput("oor.pulse", 8'(err), 8'd0);

    // Start while busy is ignored; abort wins over step.
    hx = 0; hy = 0;
    applyStimulus("ab.start", 1, 0, 0, 5, 5);
    applyStimulus("ab.step", 0, 0, 1, 0, 0);
    applyStimulus("ab.restart", 1, 0, 0, 1, 1);
    applyStimulus("ab.abort", 0, 1, 1, 0, 0);
    checkOutput("ab.no_move", 8'(move_valid), 8'd0);
    checkOutput("ab.no_done", 8'(done), 8'd0);
    checkOutput("ab.idle", 8'(busy), 8'd0);

    // Reset mid-plan, then a new plan from wherever the head ended up.
    hx = 0; hy = 0;
    applyStimulus("rst.start", 1, 0, 0, 4, 4);
    applyStimulus("rst.step1", 0, 0, 1, 0, 0);
    applyStimulus("rst.step2", 0, 0, 1, 0, 0);
    applyReset("rst");
    applyStimulus("rst.new", 1, 0, 0, 2, 1);
    applyStimulus("rst.mv", 0, 0, 1, 0, 0);
    checkOutput("rst.from_head", 8'(nextMove), 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus("rst.run", 0, 0, 1, 0, 0);

    // Frozen head keeps the plan running long enough to saturate the counter.
    moverOn = 0;
    hx = 0; hy = 0;
    applyStimulus("sat.start", 1, 0, 0, 5, 0);
    for (int i = 0; i < 262; i++) applyStimulus("sat.step", 0, 0, 1, 0, 0);
    checkOutput("sat.count", step_count, 8'd255);
    applyStimulus("sat.abort", 0, 1, 0, 0, 0);
    moverOn = 1;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599) == 0) begin
        applyReset("rnd.reset");
      end else begin
        applyStimulus("rnd",
                      ($urandom_range(7) == 0),
                      ($urandom_range(39) == 0),
                      ($urandom_range(3) != 0),
                      int'($urandom_range(14)),
                      int'($urandom_range(11)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_move_planner.md
SNAKE_MOVE_PLANNER -- requirements
Module: snake_move_planner

Interface
REQ-001 SHALL have parameters: GRID_XMAX, default 4'd11, largest x column; GRID_YMAX, default 4'd8, largest y row.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to plan toward target.
REQ-005 SHALL have port abort  input  1  cancel the active plan.
REQ-006 SHALL have port step  input  1  game tick; at most one move is issued per asserted cycle.
REQ-007 SHALL have ports target_x / target_y  input  4 / 4  destination cell, sampled on an accepted start.
REQ-008 SHALL have ports head_x / head_y  input  4 / 4  current head position fed back from the coordinate mover.
REQ-009 SHALL have port nextMove  output  2  registered move code: 00 y+1, 01 y-1, 10 x+1, 11 x-1.
REQ-010 SHALL have port move_valid  output  1  one-cycle pulse when nextMove holds a newly issued move.
REQ-011 SHALL have ports busy / done / err  output  1 each  plan active; one-cycle completion pulse; one-cycle rejection pulse.
REQ-012 SHALL have port step_count  output  8  moves issued in the current or last plan.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FINISH; busy SHALL be high exactly in RUN.
REQ-014 IDLE: start with target_x<=GRID_XMAX and target_y<=GRID_YMAX SHALL latch the target, clear step_count, and enter RUN on the next edge.
REQ-015 IDLE: start with an out-of-range target SHALL pulse err for one cycle and remain in IDLE with the target and step_count unchanged.
REQ-016 start SHALL be ignored in RUN and FINISH.
REQ-017 RUN with step=0 SHALL hold all state.
REQ-018 RUN with step=1 and head==target SHALL issue no move and enter FINISH.
REQ-019 RUN with step=1 and head_x!=target_x SHALL issue an x move; head_y SHALL be corrected only after x matches.
REQ-020 X direction SHALL use wrap-aware distance: fwd=(tx-hx) mod (GRID_XMAX+1), bwd=(GRID_XMAX+1)-fwd; fwd<bwd gives 10, fwd>bwd gives 11, a tie gives 10.
REQ-021 Y direction SHALL use the same rule with GRID_YMAX+1, choosing 00 (forward), 01 (backward), 00 on a tie.
REQ-022 An issued move SHALL load nextMove and pulse move_valid on the same edge, and increment step_count, saturating at 255.
REQ-023 nextMove SHALL hold its last value whenever move_valid is low.
REQ-024 FINISH SHALL pulse done for one cycle and return to IDLE on the next edge.
REQ-025 abort in RUN SHALL return to IDLE on the next edge with no done and no move; abort SHALL take priority over step.
REQ-026 head_x and head_y SHALL be sampled only on step cycles; the block does not track position internally.
REQ-027 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, nextMove=2'b00, move_valid=0, busy=0, done=0, err=0, step_count=0, latched target=0.
REQ-029 Reset asserted mid-RUN SHALL discard the plan; after release the block SHALL wait in IDLE for a new start.
REQ-030 Deassertion SHALL be synchronized to clk so the first active edge is clean.

Verification
REQ-031 Start target (3,2), head (0,0), one step per cycle with head updated by the mover -> moves 10,10,10,00,00; done one cycle after the step that sees head (3,2); step_count=5.
REQ-032 Start target (11,0), head (0,0) -> single 11 move (wrap); head (11,0) on the next step -> done; step_count=1.
REQ-033 Start target (6,0), head (0,0) -> tie fwd=bwd=6, so 10 is chosen on every move; start target (0,4), head (0,0) -> 00, and (0,5) -> 01.
REQ-034 Start target (12,3) -> err pulses for one cycle, busy stays 0, step_count is unchanged.
REQ-035 abort and step asserted together in RUN -> no move_valid, no done, IDLE next cycle; a start while busy is ignored.
REQ-036 reset pulsed low after two moves of a plan -> all outputs return to their reset values at once; a new start then plans from the current head.
